// File: rtl/ifetch_responder_pkg.sv
// ifetch_responder_pkg: shared FSM encoding, NOP constant and line geometry for the fetch responder.
package ifetch_responder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, RESP = 2'd2} state_e;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int OFF_W = 3;
    localparam int TAG_W = 64 - OFF_W;
    function automatic logic [31:0] sel_word(input logic [63:0] d, input logic hi);
        return hi ? d[63:32] : d[31:0];
    endfunction
endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: single doubleword line (tag, data, valid); invalidate wins over load.
module fetch_line_buffer
    import ifetch_responder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inval_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [63:0]      data_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [63:0]      data_o
);
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      data_q;
    always_ff @(posedge clk) begin
        valid_q <= (rst || inval_i) ? 1'b0 : (load_i ? 1'b1 : valid_q);
        tag_q   <= rst ? '0 : (load_i ? tag_i : tag_q);
        data_q  <= rst ? '0 : (load_i ? data_i : data_q);
    end
    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign data_o  = data_q;
endmodule

// File: rtl/ifetch_responder.sv
// ifetch_responder: instruction fetch front end with a one-line buffer, fault checks and a
// bounded wait on backing memory.
module ifetch_responder
    import ifetch_responder_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES = 64'h1000,
    parameter int          TIMEOUT   = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_instr,
    output logic        resp_fault,
    input  logic        flush,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_valid
);
    state_e           state_q, state_d;
    logic [63:2]      addr_q, addr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      instr_q, instr_d;
    logic             fault_q, fault_d;
    logic             buf_valid, fill, bad, hit;
    logic [TAG_W-1:0] buf_tag;
    logic [63:0]      buf_data;

    fetch_line_buffer u_buf (
        .clk     (CLK),
        .rst     (RST),
        .load_i  (fill),
        .inval_i (flush),
        .tag_i   (addr_q[63:OFF_W]),
        .data_i  (mem_rd_data),
        .valid_o (buf_valid),
        .tag_o   (buf_tag),
        .data_o  (buf_data)
    );

    assign bad  = (req_addr[1:0] != 2'b00) || (req_addr >= MEM_BYTES);
    // A flush on the accept edge must not be able to produce a hit from the stale line.
    assign hit  = buf_valid && !flush && (buf_tag == req_addr[63:OFF_W]);
    assign fill = (state_q == MEM_WAIT) && mem_rd_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr[63:2];
                cnt_d   = '0;
                state_d = (bad || hit) ? RESP : MEM_WAIT;
                fault_d = bad;
                instr_d = bad ? NOP : sel_word(buf_data, req_addr[2]);
            end
            MEM_WAIT: if (mem_rd_valid) begin
                state_d = RESP;
                fault_d = 1'b0;
                instr_d = sel_word(mem_rd_data, addr_q[2]);
            end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                state_d = RESP;
                fault_d = 1'b1;
                instr_d = NOP;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        resp_valid = state_q == RESP;
        mem_rd_en  = state_q == MEM_WAIT;
        mem_addr   = mem_rd_en ? {addr_q[63:OFF_W], {OFF_W{1'b0}}} : '0;
        resp_instr = instr_q;
        resp_fault = fault_q;
    end
endmodule

// File: doc/ifetch_responder.md
IFETCH_RESPONDER -- requirements
Module: ifetch_responder

Interface
REQ-001 Parameter MEM_BYTES, default 64'h1000: size of instruction memory in bytes; addresses at or above it fault.
REQ-002 Parameter TIMEOUT, default 15: maximum MEM_WAIT cycles before a fault response.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  fetch request from the program counter side.
REQ-006 req_addr  in  64  byte address of the instruction.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 resp_valid  out  1  response available.
REQ-009 resp_ready  in  1  consumer accepts the response.
REQ-010 resp_instr  out  32  fetched instruction.
REQ-011 resp_fault  out  1  misaligned, out-of-range or timed-out fetch.
REQ-012 flush  in  1  invalidate the line buffer (fence.i).
REQ-013 mem_rd_en  out  1  backing-memory read request.
REQ-014 mem_addr  out  64  doubleword-aligned read address.
REQ-015 mem_rd_data  in  64  backing-memory read data.
REQ-016 mem_rd_valid  in  1  mem_rd_data valid this cycle.

Function
REQ-017 FSM states IDLE, MEM_WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept occurs on a rising edge with req_valid=1 in IDLE; req_addr is latched.
REQ-019 Fault check at accept: req_addr[1:0]!=0 or req_addr>=MEM_BYTES -> RESP next cycle, resp_fault=1, resp_instr=32'h00000013 (NOP), no memory access.
REQ-020 Hit: buffer valid and tag==req_addr[63:3] -> RESP next cycle, resp_instr=req_addr[2] ? data[63:32] : data[31:0], no memory access.
REQ-021 Miss -> MEM_WAIT; mem_rd_en=1 and mem_addr={addr[63:3],3'b000} held stable for every MEM_WAIT cycle.
REQ-022 MEM_WAIT with mem_rd_valid=1: fill buffer (tag, data, valid=1), select word per REQ-020, enter RESP with resp_fault=0.
REQ-023 Wait counter resets to 0 on MEM_WAIT entry, increments each MEM_WAIT cycle without mem_rd_valid; reaching TIMEOUT -> RESP with resp_fault=1, resp_instr=NOP, buffer unchanged.
REQ-024 mem_rd_valid outside MEM_WAIT SHALL be ignored.
REQ-025 RESP: resp_valid=1 and resp_instr/resp_fault stable until resp_ready=1; that edge returns to IDLE; no back-to-back accept in the same cycle.
REQ-026 flush clears buffer valid on that edge in any state; flush coincident with a fill SHALL leave the buffer invalid while the response still carries the fetched word.
REQ-027 flush coincident with an accept in IDLE SHALL force a miss.
REQ-028 Minimum latency: 1 cycle accept-to-resp_valid on hit or fault; 1 + memory latency on miss.

Reset
REQ-029 RST SHALL force IDLE, buffer invalid, counter 0, req_ready=1, resp_valid=0, resp_instr=0, resp_fault=0, mem_rd_en=0, mem_addr=0.
REQ-030 RST mid-MEM_WAIT or mid-RESP SHALL abandon the transaction with no response; late mem_rd_valid is ignored.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding, the NOP constant 32'h00000013 and the doubleword offset width (3).
REQ-032 The tag/data/valid storage SHALL be a sub-module fetch_line_buffer (synchronous-reset, load and invalidate ports).

Verification
REQ-033 Miss then hit: fetch 0x100 with mem_rd_valid 3 cycles later, data 64'hAAAA_BBBB_1111_2222 -> resp_instr 0x11112222; then fetch 0x104 -> 0xAAAABBBB after 1 cycle, mem_rd_en never asserted.
REQ-034 Misaligned 0x102 -> resp_fault=1, resp_instr=0x00000013, mem_rd_en stays 0.
REQ-035 Out of range 0x1000 -> resp_fault=1; 0xFFC -> normal miss access with mem_addr=0xFF8.
REQ-036 Timeout: mem_rd_valid never asserted -> fault exactly TIMEOUT (15) MEM_WAIT cycles after entry; a subsequent fetch of the same address misses.
REQ-037 Backpressure: resp_ready low for 4 cycles -> resp_valid, resp_instr and resp_fault stable, req_ready=0 throughout.
REQ-038 flush on fill edge, then RST during MEM_WAIT -> next same-line fetch misses; after reset, outputs at REQ-029 values and a mem_rd_valid pulse produces no response.
